// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// A load or store request is accepted in IDLE, the pipeline is stalled for
// LATENCY cycles, and the access is committed on the edge entering DONE.
// Illegal requests are misaligned, out of range, or both read and write.
// They never write memory and are reported with errAddr alongside done.
// Handshake: a request (memRead|memWrite) is taken on the first posedge
// seen in IDLE. stall stays high until the completion cycle. done and
// errAddr pulse for exactly one cycle. The pipeline may change the request
// inputs only after the done cycle.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] storeVal,
    output logic [31:0] loadVal,
    output logic        stall,
    output logic        done,
    output logic        errAddr,
    output logic [1:0]  dbgState
);

    localparam int         IW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [3:0]  cnt;

    logic [31:0] addrQ;
    logic [31:0] storeQ;
    logic        rdQ;
    logic        wrQ;
    logic        errQ;

    logic        req;
    logic        commit;
    logic [31:0] cAddr;
    logic [31:0] cStore;
    logic        cRd;
    logic        cWr;
    logic        cErr;
    logic [IW-1:0] idx;

    logic [31:0] mem [DEPTH];

    // When LATENCY==1 the commit happens on the accepting edge, so the live
    // inputs are used. Otherwise the latched request is used.
    always_comb begin
        req    = memRead | memWrite;
        cAddr  = (state == IDLE) ? addr     : addrQ;
        cStore = (state == IDLE) ? storeVal : storeQ;
        cRd    = (state == IDLE) ? memRead  : rdQ;
        cWr    = (state == IDLE) ? memWrite : wrQ;
        cErr   = (cAddr[1:0] != 2'b00)
               | ({2'b00, cAddr[31:2]} >= 32'(DEPTH))
               | (cRd & cWr);
        idx    = cAddr[IW+1:2];
    end

    // Next-state and output decode; a request seen in DONE is ignored
    always_comb begin
        nextState = state;
        stall     = 1'b0;
        done      = 1'b0;
        errAddr   = 1'b0;
        case (state)
            IDLE: begin
                stall = req;
                if (req) nextState = (LATENCY > 1) ? BUSY : DONE;
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == 4'd1) nextState = DONE;
            end
            DONE: begin
                done      = 1'b1;
                errAddr   = errQ;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        commit   = (nextState == DONE) && (state != DONE);
        dbgState = state;
    end

    // State, countdown, error flag and registered load data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            loadVal <= 32'd0;
            errQ    <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE && req) cnt <= LAT_M1;
            else if (state == BUSY)   cnt <= cnt - 4'd1;
            if (commit) begin
                errQ <= cErr;
                if (cRd) begin
                    if (!cErr)     loadVal <= mem[idx];
                    else if (!cWr) loadVal <= 32'd0;
                end
            end
        end
    end

    // Capture the request only when it is accepted in IDLE
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            addrQ  <= addr;
            storeQ <= storeVal;
            rdQ    <= memRead;
            wrQ    <= memWrite;
        end
    end

    // Store commit; reset discards any pending write, contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && commit && cWr && !cRd && !cErr) mem[idx] <= cStore;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 3 and LATENCY 1),
// randomized transactions checked against an array-based reference model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] addr      [2];
    logic [31:0] store_val [2];
    logic [31:0] load_val  [2];
    logic [1:0]  stall;
    logic [1:0]  done;
    logic [1:0]  err_addr;
    logic [1:0]  dbg_state [2];

    int          lat [2] = '{3, 1};
    logic [31:0] ref_mem [2][64];
    logic [31:0] exp_load [2];
    logic [31:0] exp_q [$];
    int          n_compared   = 0;
    int          n_mismatched = 0;

    // Clock generation
    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .LATENCY(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .memRead(mem_read[0]), .memWrite(mem_write[0]),
        .addr(addr[0]), .storeVal(store_val[0]), .loadVal(load_val[0]),
        .stall(stall[0]), .done(done[0]), .errAddr(err_addr[0]), .dbgState(dbg_state[0])
    );

    data_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .memRead(mem_read[1]), .memWrite(mem_write[1]),
        .addr(addr[1]), .storeVal(store_val[1]), .loadVal(load_val[1]),
        .stall(stall[1]), .done(done[1]), .errAddr(err_addr[1]), .dbgState(dbg_state[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full transaction on instance d, with timing, error and data checks
    task automatic run_txn(input int d, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] sv);
        bit          illegal;
        logic [31:0] exp_v;
        illegal = (a[1:0] != 2'b00) || (a[31:2] >= 30'd1024) || (rd && wr);
        if (!illegal && wr) ref_mem[d][a[7:2]] = sv;
        if (rd && !wr) exp_load[d] = illegal ? 32'd0 : ref_mem[d][a[7:2]];
        exp_q.push_back(exp_load[d]);

        @(negedge clk);
        mem_read[d]  = rd;
        mem_write[d] = wr;
        addr[d]      = a;
        store_val[d] = sv;
        #1;
        for (int k = 0; k < lat[d]; k++) begin
            check_val("stall_busy", 32'(stall[d]), 32'd1);
            check_val("done_early", 32'(done[d]), 32'd0);
            @(negedge clk);
            // Scramble data while busy; the request level stays up into DONE
            addr[d]      = $urandom;
            store_val[d] = $urandom;
        end
        exp_v = exp_q.pop_front();
        check_val("done_pulse", 32'(done[d]), 32'd1);
        check_val("stall_done", 32'(stall[d]), 32'd0);
        check_val("err_addr",   32'(err_addr[d]), 32'(illegal));
        check_val("load_val",   load_val[d], exp_v);
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
        @(negedge clk);
        check_val("done_clear", 32'(done[d]), 32'd0);
        check_val("err_clear",  32'(err_addr[d]), 32'd0);
        check_val("load_hold",  load_val[d], exp_v);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 8)       return 32'($urandom_range(0, 63)) << 2;
        else if (sel == 8) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        else               return 32'($urandom_range(1024, 32'h3FFF_FFFF)) << 2;
    endfunction

    initial begin
        int          d;
        int          op;
        logic [31:0] a;

        // Reset with a request held high; it must be ignored
        rst_n     = 1'b0;
        mem_read  = 2'b11;
        mem_write = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr[i]      = 32'h0;
            store_val[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        mem_read = 2'b00;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val("rst_load",  load_val[i], 32'd0);
            check_val("rst_stall", 32'(stall[i]), 32'd0);
            check_val("rst_done",  32'(done[i]), 32'd0);
            check_val("rst_state", 32'(dbg_state[i]), 32'd0);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_val("rst_no_txn", 32'(done[i]), 32'd0);
        exp_load = '{32'd0, 32'd0};

        // Fill the model's address window in both instances
        for (int w = 0; w < 64; w++)
            for (int i = 0; i < 2; i++) run_txn(i, 1'b0, 1'b1, 32'(w) << 2, $urandom);

        // Directed cases
        run_txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        run_txn(0, 1'b1, 1'b0, 32'h10, 32'h0);
        run_txn(1, 1'b0, 1'b1, 32'h0, 32'h12345678);
        run_txn(1, 1'b1, 1'b0, 32'h0, 32'h0);
        run_txn(0, 1'b1, 1'b0, 32'h1002, 32'h0);
        run_txn(0, 1'b1, 1'b0, 32'h10, 32'h0);
        run_txn(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        run_txn(0, 1'b0, 1'b1, 32'h20, 32'h5);
        run_txn(0, 1'b1, 1'b0, 32'h10, 32'h0);
        run_txn(0, 1'b1, 1'b1, 32'h20, 32'h77);
        run_txn(0, 1'b1, 1'b0, 32'h20, 32'h0);

        // Reset in the middle of a pending write: it must not commit
        @(negedge clk);
        mem_write[0] = 1'b1;
        addr[0]      = 32'h40;
        store_val[0] = 32'hAA;
        @(negedge clk);
        check_val("mid_busy_state", 32'(dbg_state[0]), 32'd1);
        check_val("mid_busy_stall", 32'(stall[0]), 32'd1);
        rst_n        = 1'b0;
        mem_write[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("abort_stall", 32'(stall[0]), 32'd0);
        check_val("abort_done",  32'(done[0]), 32'd0);
        check_val("abort_state", 32'(dbg_state[0]), 32'd0);
        check_val("abort_load",  load_val[0], 32'd0);
        exp_load = '{32'd0, 32'd0};
        run_txn(0, 1'b1, 1'b0, 32'h40, 32'h0);

        // Randomized traffic on both instances
        for (int n = 0; n < 200; n++) begin
            d  = $urandom_range(0, 1);
            op = $urandom_range(0, 9);
            a  = rand_addr();
            if (op < 5)      run_txn(d, 1'b1, 1'b0, a, $urandom);
            else if (op < 9) run_txn(d, 1'b0, 1'b1, a, $urandom);
            else             run_txn(d, 1'b1, 1'b1, a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
